// File: rtl/button_debouncer.sv
// Purpose: two-flop synchroniser plus per-channel stability counter for raw buttons, with rise/fall event pulses.
// Latency: DEBOUNCE_CYCLES+2 clock edges from a clean input step to out/rise/fall; stable is combinational from flops.
// Backpressure: none; free-running conditioner, every channel updates independently on every edge.
module button_debouncer #(
    parameter int LENGTH          = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [LENGTH-1:0] in,
    output logic [LENGTH-1:0] out,
    output logic [LENGTH-1:0] rise,
    output logic [LENGTH-1:0] fall,
    output logic              stable
);
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [LENGTH-1:0] sync1;
    logic [LENGTH-1:0] sync2;
    logic [CW-1:0]     cnt [LENGTH];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
            out   <= '0;
            rise  <= '0;
            fall  <= '0;
            for (int i = 0; i < LENGTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= in;
            sync2 <= sync1;
            for (int i = 0; i < LENGTH; i++) begin
                rise[i] <= 1'b0;
                fall[i] <= 1'b0;
                // Any agreeing cycle throws away the partial run, so only an
                // unbroken mismatch of DEBOUNCE_CYCLES edges is accepted.
                if (sync2[i] == out[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    out[i]  <= sync2[i];
                    cnt[i]  <= '0;
                    rise[i] <= sync2[i];
                    fall[i] <= ~sync2[i];
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    assign stable = (sync2 == out);
endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: window-based reference model feeds a scoreboard queue each edge.
module tb_button_debouncer;
    localparam int L = 8;
    localparam int D = 4;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic [L-1:0] inBus = '0;
    logic [L-1:0] out, rise, fall;
    logic         stable;
    logic         cascadeOut;

    always #5 clock = ~clock;

    button_debouncer #(.LENGTH(L), .DEBOUNCE_CYCLES(D)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .in      (inBus),
        .out     (out),
        .rise    (rise),
        .fall    (fall),
        .stable  (stable)
    );

    // Stand-in for the downstream AND cascade.
    assign cascadeOut = &out;

    typedef struct packed {
        logic [L-1:0] o;
        logic [L-1:0] r;
        logic [L-1:0] f;
        logic         s;
    } exp_t;

    exp_t         sb[$];
    logic [L-1:0] samp[$];
    logic [L-1:0] mOut;
    int checks = 0;
    int failures = 0;
    int stableLow;
    int riseSeen [L];
    int fallSeen [L];
    int cascadeHigh;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelClear();
        samp.delete();
        for (int j = 0; j < D + 2; j++) samp.push_back('0);
        mOut = '0;
    endtask

    task automatic clearStats();
        stableLow   = 0;
        cascadeHigh = 0;
        for (int i = 0; i < L; i++) begin
            riseSeen[i] = 0;
            fallSeen[i] = 0;
        end
    endtask

    // samp[k] holds the input sampled k edges ago; a channel flips once the
    // D samples that reached sync2 before this edge all disagree with out.
    task automatic modelEdge();
        exp_t         e;
        logic [L-1:0] nOut;
        logic [L-1:0] s;
        if (!reset_n) begin
            modelClear();
            e = '{o: '0, r: '0, f: '0, s: 1'b1};
        end else begin
            samp.push_front(inBus);
            void'(samp.pop_back());
            nOut = mOut;
            for (int i = 0; i < L; i++) begin
                bit allMis = 1'b1;
                for (int j = 2; j <= D + 1; j++) begin
                    s = samp[j];
                    if (s[i] == mOut[i]) allMis = 1'b0;
                end
                if (allMis) nOut[i] = ~mOut[i];
            end
            e.r  = nOut & ~mOut;
            e.f  = ~nOut & mOut;
            mOut = nOut;
            e.o  = mOut;
            e.s  = (samp[1] == mOut);
        end
        sb.push_back(e);
    endtask

    task automatic tick(input logic [L-1:0] v);
        exp_t e;
        inBus = v;
        @(posedge clock);
        modelEdge();
        #1;
        e = sb.pop_front();
        chk("sb_out", 32'(out), 32'(e.o));
        chk("sb_rise", 32'(rise), 32'(e.r));
        chk("sb_fall", 32'(fall), 32'(e.f));
        chk("sb_stable", 32'(stable), 32'(e.s));
        if (!stable) stableLow++;
        if (cascadeOut) cascadeHigh++;
        for (int i = 0; i < L; i++) begin
            riseSeen[i] += int'(rise[i]);
            fallSeen[i] += int'(fall[i]);
        end
    endtask

    initial begin
        int           riseTick1, riseTick6, fallPulses;
        logic [L-1:0] fallVal;
        logic [L-1:0] prev, cur;
        int           expRise [L];
        int           expFall [L];

        modelClear();
        clearStats();

        // 1: reset with all buttons held, then step
        inBus = 8'hFF;
        #1;
        chk("rst_async_out", 32'(out), 32'h00);
        chk("rst_async_stable", 32'(stable), 32'h1);
        repeat (3) tick(8'hFF);
        chk("rst_out", 32'(out), 32'h00);
        chk("rst_rise_fall", 32'({rise, fall}), 32'h0000);
        chk("rst_stable", 32'(stable), 32'h1);
        reset_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick(8'hFF);
            if (k == 5) chk("step_out_e5", 32'(out), 32'h00);
            if (k == 6) begin
                chk("step_out_e6", 32'(out), 32'hFF);
                chk("step_rise_e6", 32'(rise), 32'hFF);
                chk("step_cascade", 32'(cascadeOut), 32'h1);
            end
            if (k == 7) chk("step_rise_e7", 32'(rise), 32'h00);
        end
        repeat (8) tick(8'h00);
        chk("clear_out", 32'(out), 32'h00);

        // 2: three-cycle glitch on bit 0
        clearStats();
        repeat (3) tick(8'h01);
        repeat (8) tick(8'h00);
        chk("glitch_rise", 32'(riseSeen[0]), 32'd0);
        chk("glitch_stable_low", 32'(stableLow), 32'd3);
        chk("glitch_out", 32'(out), 32'h00);

        // 3: bounce on bit 3, then hold high
        clearStats();
        riseTick1 = -1;
        for (int k = 0; k < 10; k++) tick((k % 2 == 0) ? 8'h08 : 8'h00);
        for (int k = 1; k <= 10; k++) begin
            tick(8'h08);
            if (rise[3] && riseTick1 < 0) riseTick1 = k;
        end
        chk("bounce_rise_edge", 32'(riseTick1), 32'd6);
        chk("bounce_rise_count", 32'(riseSeen[3]), 32'd1);
        repeat (8) tick(8'h00);

        // 4: independent channels, simultaneous release
        riseTick1 = -1;
        riseTick6 = -1;
        for (int k = 1; k <= 12; k++) begin
            tick((k <= 2) ? 8'h02 : 8'h42);
            if (rise[1]) riseTick1 = k;
            if (rise[6]) riseTick6 = k;
        end
        chk("indep_rise1_edge", 32'(riseTick1), 32'd6);
        chk("indep_rise6_edge", 32'(riseTick6), 32'd8);
        fallPulses = 0;
        fallVal = '0;
        for (int k = 1; k <= 10; k++) begin
            tick(8'h00);
            if (fall != '0) begin
                fallPulses++;
                fallVal = fall;
            end
        end
        chk("release_fall_pulses", 32'(fallPulses), 32'd1);
        chk("release_fall_val", 32'(fallVal), 32'h42);

        // 5: reset while bit 5 is mid-count, bit 0 already accepted
        repeat (8) tick(8'h01);
        repeat (4) tick(8'h21);
        chk("midcnt_pre_out", 32'(out), 32'h01);
        #2;
        reset_n = 1'b0;
        #1;
        modelClear();
        chk("midcnt_rst_out", 32'(out), 32'h00);
        chk("midcnt_rst_stable", 32'(stable), 32'h1);
        repeat (2) tick(8'h21);
        reset_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick(8'h21);
            if (k == 5) chk("midcnt_out_e5", 32'(out), 32'h00);
            if (k == 6) chk("midcnt_out_e6", 32'(out), 32'h21);
        end

        // 6: counter sweep every 8 cycles through the all-ones value
        repeat (10) tick(8'hF0);
        clearStats();
        for (int i = 0; i < L; i++) begin
            expRise[i] = 0;
            expFall[i] = 0;
        end
        prev = 8'hF0;
        for (int s = 1; s <= 24; s++) begin
            cur = prev + 8'h01;
            for (int i = 0; i < L; i++) begin
                if (!prev[i] && cur[i]) expRise[i]++;
                if (prev[i] && !cur[i]) expFall[i]++;
            end
            repeat (8) tick(cur);
            prev = cur;
        end
        repeat (10) tick(prev);
        for (int i = 0; i < L; i++) begin
            chk($sformatf("sweep_rise%0d", i), 32'(riseSeen[i]), 32'(expRise[i]));
            chk($sformatf("sweep_fall%0d", i), 32'(fallSeen[i]), 32'(expFall[i]));
        end
        chk("sweep_cascade_cycles", 32'(cascadeHigh), 32'd8);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
